// File: rtl/data_ram_responder_pkg.sv
// Shared encodings for the data-RAM responder: state codes, byte-select patterns, bus constants.
// The DRAM_ALIGN_CHECK_EN build uses sel_legal() to classify select patterns.
`ifndef DATA_RAM_RESPONDER_GLOBAL_DEF
`define DATA_RAM_RESPONDER_GLOBAL_DEF
`define STATE_IDLE  2'd0
`define STATE_WAIT  2'd1
`define STATE_RESP  2'd2
`define SEL_BYTE0   4'b0001
`define SEL_BYTE1   4'b0010
`define SEL_BYTE2   4'b0100
`define SEL_BYTE3   4'b1000
`define SEL_HALF_LO 4'b0011
`define SEL_HALF_HI 4'b1100
`define SEL_WORD    4'b1111
`define ZERO_WORD   32'h0000_0000
`define RST_ENABLE  1'b1
`define DATA_BUS    31:0
`endif

package data_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `STATE_IDLE,
    ST_WAIT = `STATE_WAIT,
    ST_RESP = `STATE_RESP
  } state_t;

  localparam int CNT_WIDTH = 4;

  // Naturally aligned byte/half/word patterns are legal; an empty select is only legal on a load.
  function automatic logic sel_legal(input logic [3:0] sel, input logic is_store);
    case (sel)
      `SEL_BYTE0, `SEL_BYTE1, `SEL_BYTE2, `SEL_BYTE3,
      `SEL_HALF_LO, `SEL_HALF_HI, `SEL_WORD: sel_legal = 1'b1;
      4'b0000: sel_legal = !is_store;
      default: sel_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_responder_dram_array.sv
// Single-port 32-bit word RAM with four byte-lane write enables and a registered read port.
// The read register has its own clear so the responder can force a zero load result.
module data_ram_responder_dram_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rd_clr,
  input  logic                  rd_en,
  input  logic [3:0]            wr_be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_clr) rdata_q <= 32'h0;
    else if (rd_en) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_responder.sv
// MEM-stage data-memory responder: accept, wait WAIT_CYCLES, commit to RAM, pulse mem_ready.
// Define DRAM_ALIGN_CHECK_EN to add mem_align_err and suppress misaligned accesses.
module data_ram_responder
  import data_ram_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write_en,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        stall_req
`ifdef DRAM_ALIGN_CHECK_EN
  , output logic      mem_align_err
`endif
);

  state_t                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [3:0]             sel_q;
  logic [31:0]            wdata_q;
  logic                   ready_q;
  logic                   err_q;

  logic                   commit_d;
  logic                   c_we_d;
  logic [ADDR_WIDTH-1:0]  c_idx_d;
  logic [3:0]             c_sel_d;
  logic [31:0]            c_wdata_d;
  logic                   c_err_d;
  logic [3:0]             ram_be_d;
  logic                   ram_re_d;
  logic                   ram_clr_d;

  // With zero wait states the commit happens on the accept edge, straight from the live inputs.
  always_comb begin
    commit_d  = ((state_q == ST_IDLE) && mem_en && (WAIT_CYCLES == 0)) ||
                ((state_q == ST_WAIT) && (cnt_q == '0));
    c_we_d    = (state_q == ST_IDLE) ? mem_write_en : we_q;
    c_idx_d   = (state_q == ST_IDLE) ? mem_addr[ADDR_WIDTH+1:2] : idx_q;
    c_sel_d   = (state_q == ST_IDLE) ? mem_sel : sel_q;
    c_wdata_d = (state_q == ST_IDLE) ? mem_write_data : wdata_q;
`ifdef DRAM_ALIGN_CHECK_EN
    c_err_d   = !sel_legal(c_sel_d, c_we_d);
`else
    c_err_d   = 1'b0;
`endif
    ram_be_d  = (commit_d && c_we_d && !c_err_d && !rst) ? c_sel_d : 4'b0000;
    ram_re_d  = commit_d && !c_we_d && !rst;
    ram_clr_d = rst || (commit_d && !c_we_d && c_err_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_en) begin
            we_q    <= mem_write_en;
            idx_q   <= mem_addr[ADDR_WIDTH+1:2];
            sel_q   <= mem_sel;
            wdata_q <= mem_write_data;
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
              err_q   <= c_err_d;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_WIDTH'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
            err_q   <= c_err_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  data_ram_responder_dram_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .rd_clr(ram_clr_d),
    .rd_en (ram_re_d),
    .wr_be (ram_be_d),
    .addr  (c_idx_d),
    .wdata (c_wdata_d),
    .rdata (mem_read_data)
  );

  assign mem_ready = ready_q;
  assign stall_req = ((state_q == ST_IDLE) && mem_en) || (state_q == ST_WAIT);

`ifdef DRAM_ALIGN_CHECK_EN
  assign mem_align_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

endmodule

// File: tb/tb_data_ram_responder.sv
// Directed test of data_ram_responder with ADDR_WIDTH=10, WAIT_CYCLES=1.
// Build with DRAM_ALIGN_CHECK_EN defined to also exercise the alignment-error path.
module tb_data_ram_responder;

  localparam int AW = 10;
  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_en = 1'b0;
  logic        mem_write_en = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        stall_req;
`ifdef DRAM_ALIGN_CHECK_EN
  logic        mem_align_err;
`endif

  int errors = 0;
  int checks = 0;

  data_ram_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_en        (mem_en),
    .mem_write_en  (mem_write_en),
    .mem_addr      (mem_addr),
    .mem_sel       (mem_sel),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .mem_ready     (mem_ready),
    .stall_req     (stall_req)
`ifdef DRAM_ALIGN_CHECK_EN
    , .mem_align_err(mem_align_err)
`endif
  );

  always #5 clk = ~clk;

  // Issue one request, drop mem_en after accept, and wait (bounded) for mem_ready.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                     input logic [31:0] wd, output int lat, output logic [31:0] rd,
                     output logic err);
    @(negedge clk);
    mem_en = 1'b1; mem_write_en = we; mem_addr = addr; mem_sel = sel; mem_write_data = wd;
    @(posedge clk);
    @(negedge clk);
    mem_en = 1'b0; mem_write_en = 1'b0; mem_write_data = 32'hDEAD_BEEF; mem_sel = 4'b0000;
    lat = -1; rd = '0; err = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (mem_ready) begin
        lat = k; rd = mem_read_data;
`ifdef DRAM_ALIGN_CHECK_EN
        err = mem_align_err;
`endif
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    $display("txn we=%0d addr=%08h sel=%04b wd=%08h -> lat=%0d rd=%08h err=%0d",
             we, addr, sel, wd, lat, rd, err);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", mem_ready); end
    checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%08h exp=00000000", mem_read_data); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    $display("reset: ready=%0b rdata=%08h stall=%0b", mem_ready, mem_read_data, stall_req);
  endtask

  task automatic test_load_latency;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h0000_0010, 4'b1111, 32'hCAFE_F00D, lat, rd, err);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL store_lat got=%0d exp=%0d", lat, WC + 1); end
    @(negedge clk);
    mem_en = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h0000_0010; mem_sel = 4'b1111;
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL stall_idle_req got=%0b exp=1", stall_req); end
    @(posedge clk);
    @(negedge clk);
    mem_en = 1'b0;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL stall_wait got=%0b exp=1", stall_req); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ready_early got=%0b exp=0", mem_ready); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL ready_2nd got=%0b exp=1", mem_ready); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL stall_resp got=%0b exp=0", stall_req); end
    checks++; if (mem_read_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL load_10 got=%08h exp=cafef00d", mem_read_data); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse got=%0b exp=0", mem_ready); end
    checks++; if (mem_read_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL rdata_hold got=%08h exp=cafef00d", mem_read_data); end
    $display("load_latency: load 0x10 done rdata=%08h", mem_read_data);
  endtask

  task automatic test_byte_merge;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h20, 4'b1111, 32'hAABB_CCDD, lat, rd, err);
    txn(1'b1, 32'h20, 4'b0001, 32'h0000_0011, lat, rd, err);
    txn(1'b0, 32'h20, 4'b1111, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hAABB_CC11) begin errors++; $display("FAIL byte_merge got=%08h exp=aabbcc11", rd); end
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL load_lat got=%0d exp=%0d", lat, WC + 1); end
  endtask

  task automatic test_half_sel;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h24, 4'b1111, 32'h0000_ABCD, lat, rd, err);
    txn(1'b1, 32'h24, 4'b1100, 32'h1234_0000, lat, rd, err);
    txn(1'b0, 32'h24, 4'b0001, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h1234_ABCD) begin errors++; $display("FAIL half_hi got=%08h exp=1234abcd", rd); end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h0000_1004, 4'b1111, 32'h5A5A_5A5A, lat, rd, err);
    txn(1'b0, 32'h0000_0004, 4'b1111, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL wrap got=%08h exp=5a5a5a5a", rd); end
  endtask

  task automatic test_sel_zero;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h20, 4'b0000, 32'hFFFF_FFFF, lat, rd, err);
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL sel0_ready got=%0d exp=%0d", lat, WC + 1); end
    txn(1'b0, 32'h20, 4'b1111, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'hAABB_CC11) begin errors++; $display("FAIL sel0_nochange got=%08h exp=aabbcc11", rd); end
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h30, 4'b1111, 32'h1111_1111, lat, rd, err);
    @(negedge clk);
    mem_en = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h30; mem_sel = 4'b1111;
    mem_write_data = 32'h2222_2222;
    @(posedge clk);
    @(negedge clk);
    mem_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%0b exp=0", mem_ready); end
    checks++; if (mem_read_data !== 32'h0) begin errors++; $display("FAIL abort_rdata got=%08h exp=00000000", mem_read_data); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL abort_late_ready got=%0b exp=0", mem_ready); end
    $display("reset_abort: store 0x22222222 to 0x30 aborted");
    txn(1'b0, 32'h30, 4'b1111, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_ram got=%08h exp=11111111", rd); end
    checks++; if (lat !== WC + 1) begin errors++; $display("FAIL abort_next_lat got=%0d exp=%0d", lat, WC + 1); end
  endtask

  task automatic test_back_to_back;
    logic [5:0] exp_ready;
    logic [5:0] exp_stall;
    exp_ready = 6'b010010;
    exp_stall = 6'b101101;
    @(negedge clk);
    mem_en = 1'b1; mem_write_en = 1'b0; mem_addr = 32'h30; mem_sel = 4'b1111;
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (mem_ready !== exp_ready[5-k]) begin
        errors++; $display("FAIL b2b_ready[%0d] got=%0b exp=%0b", k, mem_ready, exp_ready[5-k]);
      end
      checks++;
      if (stall_req !== exp_stall[5-k]) begin
        errors++; $display("FAIL b2b_stall[%0d] got=%0b exp=%0b", k, stall_req, exp_stall[5-k]);
      end
      $display("b2b cycle %0d: ready=%0b stall=%0b rdata=%08h", k, mem_ready, stall_req, mem_read_data);
    end
    mem_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

`ifdef DRAM_ALIGN_CHECK_EN
  task automatic test_align;
    int lat; logic [31:0] rd; logic err;
    txn(1'b1, 32'h24, 4'b0110, 32'hFFFF_FFFF, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL align_0110 got=%0b exp=1", err); end
    txn(1'b0, 32'h24, 4'b1111, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h1234_ABCD) begin errors++; $display("FAIL align_suppress got=%08h exp=1234abcd", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL align_load_ok got=%0b exp=0", err); end
    txn(1'b1, 32'h24, 4'b0011, 32'h0000_BEEF, lat, rd, err);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL align_0011 got=%0b exp=0", err); end
    txn(1'b0, 32'h24, 4'b0101, 32'h0, lat, rd, err);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL align_load_err got=%0b exp=1", err); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL align_load_zero got=%08h exp=00000000", rd); end
    txn(1'b0, 32'h24, 4'b1111, 32'h0, lat, rd, err);
    checks++; if (rd !== 32'h1234_BEEF) begin errors++; $display("FAIL align_write got=%08h exp=1234beef", rd); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_latency();
    test_byte_merge();
    test_half_sel();
    test_wrap();
    test_sel_zero();
    test_reset_abort();
    test_back_to_back();
`ifdef DRAM_ALIGN_CHECK_EN
    test_align();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
